// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock ratio meter.
package clk_meas_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meas_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous level with registered edge pulses.
// sync_prev is the level aligned with the cycle in which rise/fall are high.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_q,
  output logic sync_prev,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_in};
    prev_d  = chain_q[SYNC_STAGES-1];
    rise_d  = chain_q[SYNC_STAGES-1] & ~prev_q;
    fall_d  = ~chain_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sync_q    = chain_q[SYNC_STAGES-1];
  assign sync_prev = prev_q;
  assign rise      = rise_q;
  assign fall      = fall_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the period of a slow divided clock in clk_in cycles and reports the recovered divide ratio.
// Define DUTY_MEAS_EN to add the high-time counter and the high_time / duty_ok outputs.
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-2:0] ratio_n,
  output logic             odd_period,
  output logic             overrun,
  output logic             timeout
`ifdef DUTY_MEAS_EN
  ,
  output logic [CNT_W-1:0] high_time,
  output logic             duty_ok
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             capture_c;
  logic             accept_c;

  logic sync_now, sync_lvl, rise, fall_pulse;
  logic unused_sync;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .async_in (sig_in),
    .sync_q   (sync_now),
    .sync_prev(sync_lvl),
    .rise     (rise),
    .fall     (fall_pulse)
  );

  assign unused_sync = &{1'b0, sync_now, sync_lvl, fall_pulse};

  // Cycle counter, FSM and result/handshake registers
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    capture_c = 1'b0;
    accept_c  = valid_q & meas_ready;

    if (rise) timeout_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (rise) begin
            cnt_d   = CNT_W'(1);
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            capture_c = 1'b1;
            cnt_d     = CNT_W'(1);
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A capture coinciding with an accept reloads without touching overrun
    if (capture_c) begin
      period_d = cnt_q;
      valid_d  = 1'b1;
      if (valid_q && !meas_ready) overrun_d = 1'b1;
    end else if (accept_c) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign meas_valid = valid_q;
  assign period     = period_q;
  assign ratio_n    = period_q[CNT_W-1:1];
  assign odd_period = period_q[0];
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

`ifdef DUTY_MEAS_EN
  localparam logic [CNT_W+1:0] ONE_W2 = 1;

  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             duty_ok_q, duty_ok_d;

  // True when twice the high time is within one cycle of the period
  function automatic logic duty_within_one(input logic [CNT_W-1:0] hi, input logic [CNT_W-1:0] per);
    logic [CNT_W+1:0] twice;
    logic [CNT_W+1:0] per_w;
    logic [CNT_W+1:0] diff;
    twice = {1'b0, hi, 1'b0};
    per_w = {2'b00, per};
    diff  = (twice >= per_w) ? (twice - per_w) : (per_w - twice);
    return diff <= ONE_W2;
  endfunction

  always_comb begin
    high_cnt_d  = high_cnt_q;
    high_time_d = high_time_q;
    duty_ok_d   = duty_ok_q;
    if (!en || state_q == IDLE) begin
      high_cnt_d = '0;
    end else if (rise) begin
      high_cnt_d = CNT_W'(1);
    end else if (sync_lvl && high_cnt_q != CNT_MAX) begin
      high_cnt_d = high_cnt_q + CNT_W'(1);
    end
    if (capture_c) begin
      high_time_d = high_cnt_q;
      duty_ok_d   = duty_within_one(high_cnt_q, cnt_q);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt_q  <= '0;
      high_time_q <= '0;
      duty_ok_q   <= 1'b0;
    end else begin
      high_cnt_q  <= high_cnt_d;
      high_time_q <= high_time_d;
      duty_ok_q   <= duty_ok_d;
    end
  end

  assign high_time = high_time_q;
  assign duty_ok   = duty_ok_q;
`endif

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter with a divider-style sig_in generator and an expected-result queue.
module tb_clk_ratio_meter;

  localparam int unsigned CNT_W = 8;

  logic             clk_in;
  logic             rst_n;
  logic             sig_in;
  logic             en;
  logic             meas_ready;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-2:0] ratio_n;
  logic             odd_period;
  logic             overrun;
  logic             timeout;
`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] high_time;
  logic             duty_ok;
`endif

  clk_ratio_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .en        (en),
    .meas_ready(meas_ready),
    .meas_valid(meas_valid),
    .period    (period),
    .ratio_n   (ratio_n),
    .odd_period(odd_period),
    .overrun   (overrun),
    .timeout   (timeout)
`ifdef DUTY_MEAS_EN
    ,
    .high_time (high_time),
    .duty_ok   (duty_ok)
`endif
  );

  typedef struct {
    logic [31:0] period;
    logic [31:0] ratio;
    logic [31:0] odd;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  // sig_in generator: hi cycles high then lo cycles low, changing 3 units after posedge
  logic gen_on  = 1'b0;
  logic gen_sig = 1'b0;
  logic man_sig = 1'b0;
  int   hi      = 8;
  int   lo      = 8;
  int   phase   = 0;
  int   rise_cnt = 0;
  time  last_rise = 0;

  assign sig_in = gen_on ? gen_sig : man_sig;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    forever begin
      @(posedge clk_in);
      #3;
      if (gen_on) begin
        if (phase == 0) begin
          rise_cnt++;
          last_rise = $time;
        end
        gen_sig = (phase < hi);
        phase   = (phase + 1 >= hi + lo) ? 0 : phase + 1;
      end else begin
        gen_sig = 1'b0;
        phase   = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int p, input int r, input int o);
    exp_t e;
    e.period = p;
    e.ratio  = r;
    e.odd    = o;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (meas_valid !== 1'b1 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    n_asserts++;
    assert (meas_valid === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: meas_valid observed %b expected 1 within %0d cycles", tag, meas_valid, budget);
    end
  endtask

  task automatic accept_one();
    meas_ready = 1'b1;
    @(negedge clk_in);
    meas_ready = 1'b0;
  endtask

  task automatic take_result(input string tag);
    exp_t e;
    wait_valid(tag, 100);
    n_asserts++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s: result observed with empty expected queue (size %0d expected >0)", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_period"}, 32'(period), e.period);
      chk({tag, "_ratio"}, 32'(ratio_n), e.ratio);
      chk({tag, "_odd"}, 32'(odd_period), e.odd);
    end
    accept_one();
    chk({tag, "_valid_after_accept"}, 32'(meas_valid), 32'd0);
  endtask

  task automatic restart(input int h, input int l, input logic g);
    en         = 1'b0;
    gen_on     = 1'b0;
    man_sig    = 1'b0;
    meas_ready = 1'b1;
    repeat (6) @(negedge clk_in);
    meas_ready = 1'b0;
    sb.delete();
    hi     = h;
    lo     = l;
    gen_on = g;
    en     = 1'b1;
  endtask

  initial begin
    int   pulses;
    int   rc0;
    exp_t e;

    rst_n      = 1'b1;
    en         = 1'b0;
    meas_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_ratio", 32'(ratio_n), 32'd0);
    chk("rst_odd", 32'(odd_period), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;

    // Divide-by-8: period 16, ratio 8, even
    restart(8, 8, 1'b1);
    push_exp(16, 8, 0);
    take_result("n8");

    // Divide-by-3 with ready held high: one pulse per 6 cycles
    restart(3, 3, 1'b1);
    meas_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_exp(6, 3, 0);
    wait_valid("n3_first", 100);
    chk("n3_latency", 32'($time - last_rise), 32'd42);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (meas_valid === 1'b1) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("n3_period", 32'(period), e.period);
          chk("n3_ratio", 32'(ratio_n), e.ratio);
        end
      end
      @(negedge clk_in);
    end
    chk("n3_pulses", 32'(pulses), 32'd10);
    meas_ready = 1'b0;

    // One rise to arm/measure, then sig_in stuck low until the counter saturates
    restart(1, 1, 1'b0);
    repeat (4) @(negedge clk_in);
    man_sig = 1'b1;
    repeat (5) @(negedge clk_in);
    man_sig = 1'b0;
    repeat (245) @(negedge clk_in);
    chk("to_before", 32'(timeout), 32'd0);
    repeat (20) @(negedge clk_in);
    chk("to_set", 32'(timeout), 32'd1);
    chk("to_no_valid", 32'(meas_valid), 32'd0);
    man_sig = 1'b1;
    repeat (8) @(negedge clk_in);
    chk("to_cleared", 32'(timeout), 32'd0);

    // Divide-by-4 with ready low across two captures
    restart(4, 4, 1'b1);
    wait_valid("ov_first", 100);
    repeat (10) @(negedge clk_in);
    chk("ov_overrun", 32'(overrun), 32'd1);
    chk("ov_valid", 32'(meas_valid), 32'd1);
    chk("ov_period", 32'(period), 32'd8);
    accept_one();
    chk("ov_valid_clr", 32'(meas_valid), 32'd0);
    chk("ov_overrun_clr", 32'(overrun), 32'd0);

    // Reset in the middle of MEASURE, released while sig_in is low
    restart(8, 8, 1'b1);
    wait_valid("rst_mid_first", 100);
    while (sig_in !== 1'b1) @(negedge clk_in);
    while (sig_in !== 1'b0) @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_valid", 32'(meas_valid), 32'd0);
    chk("rstm_period", 32'(period), 32'd0);
    chk("rstm_ratio", 32'(ratio_n), 32'd0);
    chk("rstm_overrun", 32'(overrun), 32'd0);
    chk("rstm_timeout", 32'(timeout), 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    rc0 = rise_cnt;
    push_exp(16, 8, 0);
    wait_valid("rstm_wait", 100);
    chk("rstm_rises", 32'(rise_cnt - rc0), 32'd2);
    take_result("rstm");

`ifdef DUTY_MEAS_EN
    restart(5, 5, 1'b1);
    wait_valid("duty55", 100);
    chk("duty55_high", 32'(high_time), 32'd5);
    chk("duty55_period", 32'(period), 32'd10);
    chk("duty55_ok", 32'(duty_ok), 32'd1);
    restart(3, 7, 1'b1);
    wait_valid("duty37", 100);
    chk("duty37_high", 32'(high_time), 32'd3);
    chk("duty37_period", 32'(period), 32'd10);
    chk("duty37_ok", 32'(duty_ok), 32'd0);
`endif

    en = 1'b0;
    repeat (2) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
